// File: rtl/ib_lut_page_loader.sv
// ib_lut_page_loader: fetches IB-VNU LUT page words over a req/valid handshake and writes them
// into the VNU LUT RAMs, owning the frame offset so one half can be rewritten while the other is read.
module ib_lut_page_loader #(
  parameter int ENTRY_ADDR    = 7,
  parameter int BANK_NUM      = 2,
  parameter int LUT_PORT_SIZE = 4,
  parameter int ITER_WIDTH    = 5,
  parameter int MAX_ITER      = 20
) (
  input  logic                                write_clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ITER_WIDTH-1:0]               iter_in,
  input  logic                                half_load,
  input  logic                                swap,
  output logic                                src_req,
  output logic [ITER_WIDTH+ENTRY_ADDR-1:0]    src_addr,
  input  logic                                src_valid,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0]   src_data,
  output logic [ENTRY_ADDR-1:0]               page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0]   ram_write_data_1,
  output logic                                ib_ram_we,
  output logic                                read_addr_offset,
  output logic                                busy,
  output logic                                load_done,
  output logic                                iter_err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;
  localparam logic [ITER_WIDTH:0] MAX_ITER_W = MAX_ITER[ITER_WIDTH:0];
  state_t state, next;
  logic [ITER_WIDTH-1:0] iter_q;
  logic [ENTRY_ADDR-1:0] cnt;
  logic half_q, swap_pend, iter_ok, go, last, mid, fin, flip;
  assign iter_ok = {1'b0, iter_in} < MAX_ITER_W;
  assign go = state == IDLE && start && iter_ok;
  assign last = half_q ? &cnt[ENTRY_ADDR-2:0] : &cnt;
  assign mid = state inside {REQ, WAIT, WRITE};
  assign fin = state == WRITE && last;
  // swaps seen mid-load collapse into one toggle that lands with load_done
  assign flip = fin ? (swap | swap_pend) : !mid && swap;
  assign src_req = state == REQ;
  assign src_addr = {iter_q, cnt};
  assign ib_ram_we = state == WRITE;
  assign load_done = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = go ? REQ : IDLE;
      REQ:     next = WAIT;
      WAIT:    next = src_valid ? WRITE : WAIT;
      WRITE:   next = last ? DONE : REQ;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      iter_q <= '0;
      half_q <= 1'b0;
      cnt <= '0;
      page_addr_ram <= '0;
      ram_write_data_1 <= '0;
      read_addr_offset <= 1'b0;
      swap_pend <= 1'b0;
      iter_err <= 1'b0;
    end else begin
      state <= next;
      read_addr_offset <= read_addr_offset ^ flip;
      swap_pend <= mid && !fin && (swap | swap_pend);
      if (state == IDLE && start && !iter_ok) iter_err <= 1'b1;
      if (go) begin
        iter_q <= iter_in;
        half_q <= half_load;
        cnt <= half_load ? {~read_addr_offset, {(ENTRY_ADDR-1){1'b0}}} : '0;
      end
      if (state == WAIT && src_valid) begin
        ram_write_data_1 <= src_data;
        page_addr_ram <= cnt;
      end
      if (state == WRITE && !last) cnt <= cnt + 1'b1;
    end
  end
endmodule
